fpu_div_ctrl: RTL
=================

# fpu_div_ctrl

Issue controller and result collector for the iterative FPU divider. It queues divide requests from the FPU issue stage and starts the divider one operation at a time. It captures and acknowledges each result, then presents the result on the shared FPU register writeback port, where the pipelined FPU result has priority. It also exports a pending-destination mask that issue logic uses for hazard stalls.

## Interface
- QUEUE_DEPTH, 2, request FIFO entries; power of two, 2..8
- DRAIN_CYCLES, 33, post-reset divider flush length
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  divide request offered
- req_a  in  32  dividend, IEEE single
- req_b  in  32  divisor, IEEE single
- req_dest  in  5  destination register
- req_ready  out  1  request accepted when req_valid && req_ready
- fpu_div_start  out  1  one-cycle start pulse to divider
- fpu_a, fpu_b  out  32  operands; valid while fpu_div_start
- fpu_dest  out  5  destination; valid while fpu_div_start
- fpu_div_busy  in  1  divider busy; monitored only, never used in start logic
- div_valid  in  1  divider result valid
- div_mantissa  in  32  raw quotient bits
- div_exponent  in  8  biased exponent
- div_sign  in  1  result sign
- div_dest  in  5  result destination
- div_ack  out  1  result consumed; registered
- pipe_wb_valid  in  1  pipelined FPU owns the writeback port this cycle
- wb_valid  out  1  divider result written this cycle
- wb_mantissa  out  32
- wb_exponent  out  8
- wb_sign  out  1
- wb_dest  out  5
- pending_mask  out  32  bit d set while any request to register d is queued, in flight or held

## Operation
- FSM states: DRAIN and RUN. Reset enters DRAIN.
- DRAIN
  - Drive div_ack=1 every cycle, fpu_div_start=0 and req_ready=0.
  - Discard any div_valid.
  - After DRAIN_CYCLES cycles, go to RUN.
  - Purpose: the divider has no reset, so an operation cut short by reset runs out its count and its valid is flushed here.
- RUN
  - The FIFO accepts requests when not full: req_ready = !full. There is no pass-through when full.
  - Issue when the FIFO is non-empty and inflight=0.
    - Assert fpu_div_start for one cycle.
    - Drive fpu_a/fpu_b/fpu_dest from the FIFO head.
    - Pop the head and set inflight.
  - Capture when div_valid && !div_ack && !hold_valid.
    - Load the hold register with mantissa, exponent, sign and dest.
    - Set hold_valid and clear inflight.
    - Assert div_ack in the next cycle only, as a one-cycle pulse.
  - If hold_valid is still set when div_valid rises, do not capture or ack. The divider keeps its valid and capture retries each cycle.
  - Writeback: wb_valid = hold_valid && !pipe_wb_valid. hold_valid clears at the end of a cycle with wb_valid=1. wb_* always reflect the hold register.
  - pending_mask is combinational: the OR of one-hot(dest) over valid FIFO entries, the in-flight op and the hold register.
  - Duplicate destinations are legal. A bit clears only when no tracked entry targets that register.
- Results pass through unmodified; no rounding or normalisation.
- Never start the divider while an uncaptured result exists. This is guaranteed because inflight is held until capture.

## Timing
- Reset values:
  - fpu_div_start=0, req_ready=0, wb_valid=0 and pending_mask=0.
  - div_ack=1 during DRAIN; queue empty; inflight=0; hold_valid=0.
  - wb_* data and fpu_a/fpu_b/fpu_dest are don't-care but driven, with no X on wb_dest when wb_valid=0.
- Request accepted in cycle E → earliest start in E+1.
- Start in cycle T → div_valid in T+32 → capture T+32, div_ack T+33.
  - Earliest next start is T+33.
  - Earliest wb_valid is T+33.
- Sustained issue interval: 33 cycles.
- Simultaneous push and pop: legal when not full; FIFO count is unchanged.
- Simultaneous capture and writeback of the previous hold: not possible; capture requires hold_valid=0 at the start of the cycle.
- Reset asserted mid-operation restarts DRAIN and drops all queued and held results.

## Test plan
- Reset, then idle:
  - req_ready=0 and div_ack=1 for exactly 33 cycles, then req_ready=1 and div_ack=0.
- Single op 0x40C00000 / 0x40000000, dest 5, accepted at cycle E:
  - start at E+1; wb_valid at E+34 with wb_dest=5 and wb_exponent=0x80.
  - pending_mask=0x20 from E+1 through E+34, then 0.
- Three back-to-back requests with QUEUE_DEPTH=2:
  - req_ready drops when the queue holds 2 entries.
  - Starts are 33 cycles apart; writebacks occur in request order.
- pipe_wb_valid held high for 40 cycles across a result:
  - wb_valid stays 0 and the result is retained.
  - The next division's div_valid is not acked until the hold register drains; no result is lost.
- Reset pulsed 10 cycles after a start:
  - DRAIN absorbs the divider's late valid; no wb_valid.
  - A post-drain request completes correctly.
- Two requests to dest 3:
  - pending_mask[3] stays set until the second writeback.

Source files
------------

// File: rtl/fpu_div_ctrl_if.sv
// Bundle of the issue, divider and writeback signals around the FPU divide controller.
// slave is the controller's view; master is the surrounding FPU/divider side.
interface fpu_div_ctrl_if;
  logic        req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_dest;
  logic        req_ready;

  logic        fpu_div_start;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [4:0]  fpu_dest;
  logic        fpu_div_busy;

  logic        div_valid;
  logic [31:0] div_mantissa;
  logic [7:0]  div_exponent;
  logic        div_sign;
  logic [4:0]  div_dest;
  logic        div_ack;

  logic        pipe_wb_valid;
  logic        wb_valid;
  logic [31:0] wb_mantissa;
  logic [7:0]  wb_exponent;
  logic        wb_sign;
  logic [4:0]  wb_dest;
  logic [31:0] pending_mask;

  modport slave (
    input  req_valid, req_a, req_b, req_dest,
    output req_ready,
    output fpu_div_start, fpu_a, fpu_b, fpu_dest,
    input  fpu_div_busy,
    input  div_valid, div_mantissa, div_exponent, div_sign, div_dest,
    output div_ack,
    input  pipe_wb_valid,
    output wb_valid, wb_mantissa, wb_exponent, wb_sign, wb_dest,
    output pending_mask
  );

  modport master (
    output req_valid, req_a, req_b, req_dest,
    input  req_ready,
    input  fpu_div_start, fpu_a, fpu_b, fpu_dest,
    output fpu_div_busy,
    output div_valid, div_mantissa, div_exponent, div_sign, div_dest,
    input  div_ack,
    output pipe_wb_valid,
    input  wb_valid, wb_mantissa, wb_exponent, wb_sign, wb_dest,
    input  pending_mask
  );
endinterface

// File: rtl/fpu_div_ctrl.sv
// Issue queue, single-op divider sequencing, result hold register and writeback
// arbitration for the iterative FPU divider, plus the pending-destination hazard mask.
module fpu_div_ctrl #(
  parameter int QUEUE_DEPTH  = 2,
  parameter int DRAIN_CYCLES = 33
) (
  input  logic           clock,
  input  logic           reset,
  fpu_div_ctrl_if.slave  bus
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic {
    DRAIN = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [DRN_W-1:0]   drain_cnt_q;

  logic [31:0]        q_a    [QUEUE_DEPTH];
  logic [31:0]        q_b    [QUEUE_DEPTH];
  logic [4:0]         q_dest [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_vld;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;

  logic               inflight_q;
  logic [4:0]         infl_dest_q;

  logic               hold_valid_q;
  logic [31:0]        hold_mant_q;
  logic [7:0]         hold_exp_q;
  logic               hold_sign_q;
  logic [4:0]         hold_dest_q;
  logic               ack_q;

  logic               ready;
  logic               push;
  logic               pop;
  logic               capture;
  logic               wb_fire;
  logic [31:0]        pending;

  assign full  = (count == CNT_W'(QUEUE_DEPTH));
  assign empty = (count == '0);

  // Control FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= DRAIN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + DRN_W'(1) : '0;
    end
  end

  // Control FSM: next state and per-cycle strobes
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    pop     = 1'b0;
    capture = 1'b0;
    if (state_q == DRAIN) begin
      if (drain_cnt_q == DRN_W'(DRAIN_CYCLES - 1)) state_d = RUN;
    end else begin
      ready   = !full;
      pop     = !empty && !inflight_q;
      // The divider keeps div_valid up until acked, so a blocked capture simply retries.
      capture = bus.div_valid && !ack_q && !hold_valid_q;
    end
  end

  assign push    = bus.req_valid && ready;
  assign wb_fire = hold_valid_q && !bus.pipe_wb_valid;

  // Request queue: control
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + PTR_W'(1);
        q_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PTR_W'(1);
        q_vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Request queue: payload
  always_ff @(posedge clock) begin
    if (push) begin
      q_a[wr_ptr]    <= bus.req_a;
      q_b[wr_ptr]    <= bus.req_b;
      q_dest[wr_ptr] <= bus.req_dest;
    end
  end

  // In-flight tracking: the divider is never restarted until its result is captured
  always_ff @(posedge clock) begin
    if (reset) begin
      inflight_q <= 1'b0;
    end else if (pop) begin
      inflight_q <= 1'b1;
    end else if (capture) begin
      inflight_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (pop) infl_dest_q <= q_dest[rd_ptr];
  end

  // Result hold register and registered acknowledge
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      ack_q        <= 1'b1;
    end else begin
      if (capture) begin
        hold_valid_q <= 1'b1;
      end else if (wb_fire) begin
        hold_valid_q <= 1'b0;
      end
      ack_q <= (state_d == DRAIN) || capture;
    end
  end

  // wb_dest is kept X-free from reset even though it is only meaningful with wb_valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_dest_q <= '0;
    end else if (capture) begin
      hold_dest_q <= bus.div_dest;
    end
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      hold_mant_q <= bus.div_mantissa;
      hold_exp_q  <= bus.div_exponent;
      hold_sign_q <= bus.div_sign;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (q_vld[i]) pending[q_dest[i]] = 1'b1;
    end
    if (inflight_q)   pending[infl_dest_q] = 1'b1;
    if (hold_valid_q) pending[hold_dest_q] = 1'b1;
  end

  assign bus.req_ready     = ready;
  assign bus.fpu_div_start = pop;
  assign bus.fpu_a         = q_a[rd_ptr];
  assign bus.fpu_b         = q_b[rd_ptr];
  assign bus.fpu_dest      = q_dest[rd_ptr];
  assign bus.div_ack       = ack_q;
  assign bus.wb_valid      = wb_fire;
  assign bus.wb_mantissa   = hold_mant_q;
  assign bus.wb_exponent   = hold_exp_q;
  assign bus.wb_sign       = hold_sign_q;
  assign bus.wb_dest       = hold_dest_q;
  assign bus.pending_mask  = pending;

`ifndef SYNTHESIS
  // Busy is observed only; a start while the divider reports busy means sequencing broke.
  start_while_busy: assert property (@(posedge clock) disable iff (reset)
    !(pop && bus.fpu_div_busy));
`endif

endmodule
